alu_mdu_decoder: RTL and testbench

- Next-generation ALU control for the MIPS core.
- Performs the full ALUOp/Funct → ALUControl decode, extended with XOR, NOR and SLTU.
- Adds a multi-cycle multiply/divide unit (MDU) with architectural HI/LO registers, covering MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Sits in the EX stage. Drives the ALU select and a stall request to the hazard unit.

---
 rtl/mips_alu_pkg.sv | 60 ++++++
 rtl/alu_mdu_decoder_mdu_core.sv | 112 +++++++++++
 rtl/alu_mdu_decoder.sv | 79 +++++++
 tb/tb_alu_mdu_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the multiply/divide unit.
// ALU selects, ALUOp codes, funct constants and the MDU state type.
package mips_alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_FIX  = 2'd3
    } mdu_state_e;

    // Operation context captured at accept time, consumed in the fix-up cycle.
    typedef struct packed {
        logic is_div;
        logic neg_lo;
        logic neg_hi;
    } mdu_ctl_t;

    // MFHI/MTHI/MFLO/MTLO (0100xx) and MULT/MULTU/DIV/DIVU (0110xx).
    function automatic logic is_mdu_funct(input logic [5:0] fn);
        return (fn[5:4] == 2'b01) && !fn[2];
    endfunction

    function automatic logic is_muldiv_funct(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_mdu_decoder_mdu_core.sv
// Iterative multiply/divide with HI/LO: accept at E0, results at E(WIDTH+1), done pulse after.
// No internal backpressure; start is ignored unless idle and the caller must hold the op.
module mdu_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_div,
    input  logic             start_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    import mips_alu_pkg::*;

    mdu_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    mdu_ctl_t           ctl;

    logic               a_neg, b_neg, last_step, div_ge;
    logic [WIDTH-1:0]   a_mag, b_mag, div_diff, div_rem, fix_hi, fix_lo;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg     = start_signed & op_a[WIDTH-1];
    assign b_neg     = start_signed & op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= MDU_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE:         if (start) state_nxt = start_div ? MDU_DIV : MDU_MUL;
            MDU_MUL, MDU_DIV: if (last_step) state_nxt = MDU_FIX;
            MDU_FIX:          state_nxt = MDU_IDLE;
            default:          state_nxt = MDU_IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, opnd};
    assign div_diff  = div_trial[WIDTH-1:0] - opnd;
    assign div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];

    assign prod_fix  = ctl.neg_lo ? -acc : acc;

    always_comb begin
        fix_lo = prod_fix[WIDTH-1:0];
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        if (ctl.is_div) begin
            fix_lo = ctl.neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi = ctl.neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            MDU_IDLE: if (start) begin
                acc        <= {{WIDTH{1'b0}}, start_div ? a_mag : b_mag};
                opnd       <= start_div ? b_mag : a_mag;
                ctl.is_div <= start_div;
                // A zero divisor keeps the all-ones quotient unsigned.
                ctl.neg_lo <= (a_neg ^ b_neg) & (!start_div | (|op_b));
                ctl.neg_hi <= start_div ? a_neg : (a_neg ^ b_neg);
            end
            MDU_MUL: acc <= {mul_sum, acc[WIDTH-1:1]};
            MDU_DIV: acc <= {div_rem, acc[WIDTH-2:0], div_ge};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != MDU_IDLE);
            done <= (state == MDU_FIX);
            if (state == MDU_MUL || state == MDU_DIV) cnt <= cnt + CNT_W'(1);
            else                                      cnt <= '0;
            if (state == MDU_FIX) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
            end
        end
    end

endmodule

// File: rtl/alu_mdu_decoder.sv
// EX-stage ALU select decode plus MDU front end; ALUControl is combinational, mult/div take WIDTH+1 cycles.
// MDU ops presented while busy raise stall; the hazard unit re-presents them until busy falls.
module alu_mdu_decoder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Funct,
    input  logic [1:0]       ALUOp,
    input  logic             en,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] mdu_rd_data,
    output logic             stall,
    output logic             busy,
    output logic             done
);
    import mips_alu_pkg::*;

    logic             rtype, mdu_op, start, wr_hi, wr_lo;
    logic [WIDTH-1:0] hi, lo;

    assign rtype  = en & (ALUOp == ALUOP_RTYPE);
    assign mdu_op = rtype & is_mdu_funct(Funct);
    assign start  = rtype & is_muldiv_funct(Funct) & ~busy;
    assign wr_hi  = rtype & (Funct == FN_MTHI) & ~busy;
    assign wr_lo  = rtype & (Funct == FN_MTLO) & ~busy;
    assign stall  = busy & mdu_op;

    always_comb begin
        ALUControl = ALU_AND;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            default: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_XOR:  ALUControl = ALU_XOR;
                    FN_NOR:  ALUControl = ALU_NOR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    FN_SLTU: ALUControl = ALU_SLTU;
                    default: ALUControl = ALU_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        mdu_rd_data = '0;
        if (rtype && Funct == FN_MFHI) mdu_rd_data = hi;
        if (rtype && Funct == FN_MFLO) mdu_rd_data = lo;
    end

    mdu_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mdu_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_div    (Funct[1]),
        .start_signed (~Funct[0]),
        .op_a         (SrcA),
        .op_b         (SrcB),
        .wr_hi        (wr_hi),
        .wr_lo        (wr_lo),
        .wr_data      (SrcA),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

endmodule

// File: tb/tb_alu_mdu_decoder.sv
// Randomised and directed bench for alu_mdu_decoder against a plain-arithmetic reference model.
module tb_alu_mdu_decoder;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  Funct;
    logic [1:0]  ALUOp;
    logic        en;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] mdu_rd_data;
    logic        stall, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    alu_mdu_decoder #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Funct       (Funct),
        .ALUOp       (ALUOp),
        .en          (en),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .ALUControl  (ALUControl),
        .mdu_rd_data (mdu_rd_data),
        .stall       (stall),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [2:0] model_alu(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 3'b010;
        if (op == 2'b01) return 3'b110;
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b100110: return 3'b011;
            6'b100111: return 3'b100;
            6'b101010: return 3'b111;
            6'b101011: return 3'b101;
            default:   return 3'b000;
        endcase
    endfunction

    // Returns {HI, LO}.
    function automatic logic [63:0] model_mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (fn)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        en = 1'b0; ALUOp = 2'b00; Funct = 6'd0; SrcA = 32'd0; SrcB = 32'd0;
    endtask

    // Presents an op for one edge; returns #1 after that edge with inputs idle.
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        en = 1'b1; ALUOp = 2'b10; Funct = fn; SrcA = a; SrcB = b;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Counts busy cycles after an accept; done must stay low while busy, pulse once, then drop.
    task automatic wait_mdu(output int bc, output bit done_ok, output bit to);
        bit fin;
        bc = 0; done_ok = 1'b1; fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (!busy) fin = 1'b1;
            else begin
                if (done) done_ok = 1'b0;
                bc++;
            end
        end
        to = !fin;
        if (!done) done_ok = 1'b0;
        @(negedge clk);
        if (done) done_ok = 1'b0;
    endtask

    // Called just after a negedge; reads HI then LO through mdu_rd_data.
    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        en = 1'b1; ALUOp = 2'b10; Funct = F_MFHI;
        #1 h = mdu_rd_data;
        Funct = F_MFLO;
        #1 l = mdu_rd_data;
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] h, l;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        read_hilo(h, l);
        n_cmp++; if (h !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", h); end
        n_cmp++; if (l !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", l); end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [5:0] fnl [9];
        logic [2:0] exl [9];
        logic [1:0] op;
        logic [5:0] fn;
        logic [2:0] exp_c;
        fnl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                6'b100111, 6'b101010, 6'b101011, 6'b111111};
        exl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111, 3'b101, 3'b000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            en = 1'b0; ALUOp = 2'b10; Funct = fnl[i];
            #1;
            n_cmp++;
            if (ALUControl !== exl[i]) begin
                n_err++;
                $display("FAIL decode_fixed funct=%b: got %b want %b", fnl[i], ALUControl, exl[i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 1) == 0) ? fnl[$urandom_range(0, 8)] : 6'($urandom);
            exp_c = model_alu(op, fn);
            @(negedge clk);
            en = 1'($urandom); ALUOp = op; Funct = fn;
            if (en && op == 2'b10) en = 1'b0;
            #1;
            n_cmp++;
            if (ALUControl !== exp_c) begin
                n_err++;
                $display("FAIL decode_rand op=%b funct=%b: got %b want %b", op, fn, ALUControl, exp_c);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mult();
        logic [5:0]  fns [4];
        logic [31:0] as [4], bs [4], ehs [4], els [4];
        logic [31:0] h, l;
        int bc; bit dok, to;
        fns = '{F_MULT, F_MULTU, F_MULT, F_MULTU};
        as  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF};
        bs  = '{32'h0000_0003, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF};
        ehs = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h4000_0000, 32'hFFFF_FFFE};
        els = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            issue(fns[i], as[i], bs[i]);
            wait_mdu(bc, dok, to);
            read_hilo(h, l);
            n_cmp++; if (to || bc != 33) begin n_err++; $display("FAIL mult_busy[%0d]: got %0d cycles want 33", i, bc); end
            n_cmp++; if (!dok) begin n_err++; $display("FAIL mult_done[%0d]: got bad done pulse want single pulse", i); end
            n_cmp++; if (h !== ehs[i]) begin n_err++; $display("FAIL mult_hi[%0d]: got %h want %h", i, h, ehs[i]); end
            n_cmp++; if (l !== els[i]) begin n_err++; $display("FAIL mult_lo[%0d]: got %h want %h", i, l, els[i]); end
        end
    endtask

    task automatic test_div();
        logic [5:0]  fns [6];
        logic [31:0] as [6], bs [6], ehs [6], els [6];
        logic [31:0] h, l;
        int bc; bit dok, to;
        fns = '{F_DIV, F_DIV, F_DIVU, F_DIV, F_DIVU, F_DIV};
        as  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd7};
        bs  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd10, 32'hFFFF_FFFE};
        ehs = '{32'hFFFF_FFFF, 32'h0, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'd1};
        els = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1999_9999, 32'hFFFF_FFFD};
        for (int i = 0; i < 6; i++) begin
            issue(fns[i], as[i], bs[i]);
            wait_mdu(bc, dok, to);
            read_hilo(h, l);
            n_cmp++; if (to || bc != 33) begin n_err++; $display("FAIL div_busy[%0d]: got %0d cycles want 33", i, bc); end
            n_cmp++; if (!dok) begin n_err++; $display("FAIL div_done[%0d]: got bad done pulse want single pulse", i); end
            n_cmp++; if (h !== ehs[i]) begin n_err++; $display("FAIL div_hi[%0d]: got %h want %h", i, h, ehs[i]); end
            n_cmp++; if (l !== els[i]) begin n_err++; $display("FAIL div_lo[%0d]: got %h want %h", i, l, els[i]); end
        end
    endtask

    task automatic test_stall_mflo();
        logic [63:0] exp_hl;
        int sc; bit fin;
        exp_hl = model_mdu(F_MULT, 32'h0001_2345, 32'hFFFF_6789);
        issue(F_MULT, 32'h0001_2345, 32'hFFFF_6789);
        en = 1'b1; ALUOp = 2'b10; Funct = F_MFLO;
        sc = 0; fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (stall) sc++;
            else fin = 1'b1;
        end
        #1;
        n_cmp++; if (!fin || sc != 33) begin n_err++; $display("FAIL mflo_stall: got %0d cycles want 33", sc); end
        n_cmp++; if (mdu_rd_data !== exp_hl[31:0]) begin n_err++; $display("FAIL mflo_data: got %h want %h", mdu_rd_data, exp_hl[31:0]); end
        idle_inputs();
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] h, l;
        @(negedge clk);
        en = 1'b1; ALUOp = 2'b10; Funct = F_MTHI; SrcA = 32'h1234_5678;
        @(negedge clk);
        read_hilo(h, l);
        n_cmp++; if (h !== 32'h1234_5678) begin n_err++; $display("FAIL mthi: got %h want 12345678", h); end
        en = 1'b1; ALUOp = 2'b10; Funct = F_MTLO; SrcA = 32'h9ABC_DEF0;
        @(negedge clk);
        read_hilo(h, l);
        n_cmp++; if (l !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL mtlo: got %h want 9abcdef0", l); end
        n_cmp++; if (h !== 32'h1234_5678) begin n_err++; $display("FAIL mtlo_keeps_hi: got %h want 12345678", h); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l;
        int sc, bc; bit fin, dok, to;
        issue(F_MULTU, 32'd5, 32'd7);
        en = 1'b1; ALUOp = 2'b10; Funct = F_DIVU; SrcA = 32'd100; SrcB = 32'd7;
        sc = 0; fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (stall) sc++;
            else fin = 1'b1;
        end
        n_cmp++; if (!fin || sc != 33) begin n_err++; $display("FAIL b2b_stall: got %0d cycles want 33", sc); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b want 1", done); end
        @(posedge clk);
        #1;
        idle_inputs();
        wait_mdu(bc, dok, to);
        read_hilo(h, l);
        n_cmp++; if (to || bc != 33 || !dok) begin n_err++; $display("FAIL b2b_second_timing: got %0d cycles done_ok=%b want 33/1", bc, dok); end
        n_cmp++; if (h !== 32'd2 || l !== 32'd14) begin n_err++; $display("FAIL b2b_result: got hi=%h lo=%h want 2/e", h, l); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        int dcnt, bc; bit dok, to;
        issue(F_DIV, 32'h7FFF_FFFF, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
        read_hilo(h, l);
        n_cmp++; if (h !== 32'd0 || l !== 32'd0) begin n_err++; $display("FAIL midrst_hilo: got hi=%h lo=%h want 0/0", h, l); end
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        n_cmp++; if (dcnt != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dcnt); end
        issue(F_MULT, 32'd3, 32'd4);
        wait_mdu(bc, dok, to);
        read_hilo(h, l);
        n_cmp++; if (to || bc != 33 || !dok) begin n_err++; $display("FAIL midrst_mult_timing: got %0d cycles done_ok=%b want 33/1", bc, dok); end
        n_cmp++; if (h !== 32'd0 || l !== 32'd12) begin n_err++; $display("FAIL midrst_mult: got hi=%h lo=%h want 0/c", h, l); end
    endtask

    task automatic test_random_mdu();
        logic [5:0]  fn;
        logic [31:0] a, b, h, l;
        logic [63:0] exp_hl;
        int bc; bit dok, to;
        for (int i = 0; i < 24; i++) begin
            fn = {4'b0110, 2'($urandom_range(0, 3))};
            a = pick_operand();
            b = pick_operand();
            exp_hl = model_mdu(fn, a, b);
            issue(fn, a, b);
            wait_mdu(bc, dok, to);
            read_hilo(h, l);
            n_cmp++; if (to || bc != 33 || !dok) begin n_err++; $display("FAIL rand_timing[%0d]: got %0d cycles done_ok=%b want 33/1", i, bc, dok); end
            n_cmp++;
            if ({h, l} !== exp_hl) begin
                n_err++;
                $display("FAIL rand_result[%0d] fn=%b a=%h b=%h: got %h_%h want %h", i, fn, a, b, h, l, exp_hl);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_stall_mflo();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid();
        test_random_mdu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
